// File: rtl/icache_block_fill_ctrl_if.sv
// Word-wide instruction memory read port used by the block fill controller.
// The controller is the master: it raises mem_req with mem_addr; the memory answers with mem_ack/mem_rdata.
interface icache_block_fill_ctrl_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) ();

  logic                     mem_req;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_ack;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/icache_block_fill_ctrl.sv
// One-line instruction block buffer: serves 4-word blocks to fetch with zero-cycle hits and
// refills the line on a miss with four single-word handshaked reads from instruction memory.
module icache_block_fill_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDRESS_WIDTH-1:0]    PC_in,
  input  logic                        Rd_en,
  input  logic                        Abort,
  output logic [4*DATA_WIDTH-1:0]     Dout,
  output logic                        Dout_valid,
  output logic                        fill_busy,
  icache_block_fill_ctrl_if.master    mem
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                     state;
  state_t                     state_nxt;

  logic [1:0]                 cnt;
  logic [ADDRESS_WIDTH-3:0]   base;
  logic [ADDRESS_WIDTH-3:0]   tag;
  logic                       line_valid;
  logic [4*DATA_WIDTH-1:0]    line;

  logic                       hit;
  logic                       start_fill;
  logic                       word_we;
  logic                       fill_done;
  logic                       fill_abort;

  // Word-select bits of PC_in do not take part in block lookup.
  logic                       unused_pc_lsb;
  assign unused_pc_lsb = ^PC_in[1:0];

  assign hit        = line_valid && (tag == PC_in[ADDRESS_WIDTH-1:2]);
  assign Dout       = line;
  assign Dout_valid = hit;
  assign fill_busy  = (state == FILL);

  // Request is a pure function of state, so reset drops it without waiting for a clock edge.
  assign mem.mem_req  = (state == FILL);
  assign mem.mem_addr = {base, cnt};

  always_comb begin
    state_nxt  = state;
    start_fill = 1'b0;
    word_we    = 1'b0;
    fill_done  = 1'b0;
    fill_abort = 1'b0;
    case (state)
      IDLE: begin
        if (Rd_en && !Abort && !hit) begin
          start_fill = 1'b1;
          state_nxt  = FILL;
        end
      end
      FILL: begin
        // A flush wins over a same-cycle ack; that word is dropped.
        if (Abort) begin
          fill_abort = 1'b1;
          state_nxt  = IDLE;
        end else if (mem.mem_ack) begin
          word_we = 1'b1;
          if (cnt == 2'd3) begin
            fill_done = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      base       <= '0;
      tag        <= '0;
      line_valid <= 1'b0;
      line       <= '0;
    end else begin
      state <= state_nxt;

      if (start_fill) begin
        base       <= PC_in[ADDRESS_WIDTH-1:2];
        cnt        <= 2'd0;
        line_valid <= 1'b0;
      end else if (fill_abort) begin
        cnt <= 2'd0;
      end else if (word_we) begin
        // Wraps to 0 on the last word; blocks are 4-word aligned so nothing carries into base.
        cnt <= cnt + 2'd1;
      end

      if (fill_done) begin
        tag        <= base;
        line_valid <= 1'b1;
      end

      for (int i = 0; i < 4; i++) begin
        if (word_we && (cnt == 2'(i))) begin
          line[i*DATA_WIDTH +: DATA_WIDTH] <= mem.mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_block_fill_ctrl.sv
// Directed bench for icache_block_fill_ctrl with scoreboard queues for memory requests and served blocks.
module tb_icache_block_fill_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  PC_in;
  logic         Rd_en;
  logic         Abort;
  logic [127:0] Dout;
  logic         Dout_valid;
  logic         fill_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0]  exp_addr[$];
  logic [127:0] exp_blk[$];

  icache_block_fill_ctrl_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) mif ();

  icache_block_fill_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .PC_in      (PC_in),
    .Rd_en      (Rd_en),
    .Abort      (Abort),
    .Dout       (Dout),
    .Dout_valid (Dout_valid),
    .fill_busy  (fill_busy),
    .mem        (mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: every accepted word and every served block is matched against the queues.
  always @(negedge clk) begin
    if (!reset && mif.mem_req && mif.mem_ack && !Abort) begin
      if (exp_addr.size() == 0) begin
        check("unexpected_mem_ack", mif.mem_addr, 128'hFFFF_FFFF);
      end else begin
        check("mem_addr", mif.mem_addr, exp_addr.pop_front());
      end
    end
    if (!reset && Rd_en && Dout_valid) begin
      if (exp_blk.size() == 0) begin
        check("unexpected_block", Dout, '1);
      end else begin
        check("block", Dout, exp_blk.pop_front());
      end
    end
  end

  // Issues a miss at pc, serves four words with 'waits' idle cycles before each ack,
  // then measures cycles from the miss to Dout_valid.
  task automatic request_fill(input logic [31:0] pc, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3, input int waits,
                              input int exp_lat, input string nm);
    logic [31:0] d[4];
    bit seen;
    d = '{d0, d1, d2, d3};
    PC_in = pc;
    Rd_en = 1'b1;
    mem_idle();
    exp_blk.push_back({d3, d2, d1, d0});
    cyc = 0;
    @(negedge clk);
    check({nm, "_miss_valid"}, Dout_valid, 1'b0);
    tick();
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < waits; k++) begin
        mif.mem_ack = 1'b0;
        @(negedge clk);
        check({nm, "_hold_addr"}, mif.mem_addr, {pc[31:2], 2'(w)});
        tick();
      end
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = d[w];
      exp_addr.push_back({pc[31:2], 2'(w)});
      tick();
    end
    mem_idle();
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (Dout_valid) seen = 1'b1;
      else tick();
    end
    check({nm, "_valid_seen"}, seen, 1'b1);
    check({nm, "_latency"}, cyc, exp_lat);
    tick();
    Rd_en = 1'b0;
  endtask

  task automatic mem_idle();
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    PC_in = 32'h0;
    Rd_en = 1'b0;
    Abort = 1'b0;
    mem_idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_valid", Dout_valid, 1'b0);
    check("rst_mem_req", mif.mem_req, 1'b0);
    check("rst_dout", Dout, 128'h0);
    check("rst_fill_busy", fill_busy, 1'b0);
    check("rst_mem_addr", mif.mem_addr, 32'h0);
    reset = 1'b0;
    tick();

    // PC 0 right after reset must miss (tag 0 is not valid) and enter FILL; then flush it.
    Rd_en = 1'b1;
    PC_in = 32'h0;
    @(negedge clk);
    check("pc0_miss", Dout_valid, 1'b0);
    tick();
    Rd_en = 1'b0;
    @(negedge clk);
    check("pc0_fill_busy", fill_busy, 1'b1);
    check("pc0_mem_req", mif.mem_req, 1'b1);
    check("pc0_mem_addr", mif.mem_addr, 32'h0);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    @(negedge clk);
    check("pc0_abort_req", mif.mem_req, 1'b0);
    check("pc0_abort_busy", fill_busy, 1'b0);
    tick();

    request_fill(32'h40, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 5, "cold");

    // Hits ignore PC bits [1:0] and never touch memory.
    tick();
    PC_in = 32'h42;
    Rd_en = 1'b1;
    exp_blk.push_back({32'hA3, 32'hA2, 32'hA1, 32'hA0});
    @(negedge clk);
    check("hit42_valid", Dout_valid, 1'b1);
    check("hit42_req", mif.mem_req, 1'b0);
    tick();
    PC_in = 32'h43;
    exp_blk.push_back({32'hA3, 32'hA2, 32'hA1, 32'hA0});
    @(negedge clk);
    check("hit43_valid", Dout_valid, 1'b1);
    check("hit43_req", mif.mem_req, 1'b0);
    tick();
    request_fill(32'h44, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 0, 5, "miss44");

    tick();
    request_fill(32'h48, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 3, 17, "wait");

    // Abort on the word-2 request while memory acks: word 2 keeps the old C2.
    tick();
    PC_in = 32'h4C;
    Rd_en = 1'b1;
    @(negedge clk);
    tick();
    Rd_en = 1'b0;
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'hD0;
    exp_addr.push_back(32'h4C);
    tick();
    mif.mem_rdata = 32'hD1;
    exp_addr.push_back(32'h4D);
    tick();
    Abort = 1'b1;
    mif.mem_rdata = 32'hDEAD;
    @(negedge clk);
    check("abort_word2_addr", mif.mem_addr, 32'h4E);
    tick();
    Abort = 1'b0;
    mem_idle();
    @(negedge clk);
    check("abort_mem_req", mif.mem_req, 1'b0);
    check("abort_fill_busy", fill_busy, 1'b0);
    check("abort_dout_valid", Dout_valid, 1'b0);
    check("abort_line", Dout, {32'hC3, 32'hC2, 32'hD1, 32'hD0});

    // Abort in IDLE suppresses the fill start.
    tick();
    PC_in = 32'h80;
    Rd_en = 1'b1;
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    Rd_en = 1'b0;
    @(negedge clk);
    check("idle_abort_req", mif.mem_req, 1'b0);
    tick();
    request_fill(32'h80, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 0, 5, "fresh80");

    // Reset after word 1 of a fill: request drops at once, then a full refill follows.
    tick();
    PC_in = 32'h90;
    Rd_en = 1'b1;
    @(negedge clk);
    tick();
    Rd_en = 1'b0;
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h5F0;
    exp_addr.push_back(32'h90);
    tick();
    mif.mem_rdata = 32'h5F1;
    exp_addr.push_back(32'h91);
    tick();
    mem_idle();
    check("pre_rst_req", mif.mem_req, 1'b1);
    check("pre_rst_addr", mif.mem_addr, 32'h92);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_mem_req", mif.mem_req, 1'b0);
    check("midrst_fill_busy", fill_busy, 1'b0);
    check("midrst_dout_valid", Dout_valid, 1'b0);
    check("midrst_dout", Dout, 128'h0);
    #1;
    reset = 1'b0;
    tick();
    request_fill(32'h90, 32'h6F0, 32'h6F1, 32'h6F2, 32'h6F3, 0, 5, "refill90");

    repeat (3) tick();
    check("addr_queue_drained", exp_addr.size(), 0);
    check("block_queue_drained", exp_blk.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
